// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the MIPS datapath: fetch/decode/execute/memory/write-back
// with a RAM request/MOC handshake guarded by a watchdog.
module multicycle_control_fsm #(
    parameter int MOC_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       moc,
    output logic       ir_load,
    output logic       pc_load,
    output logic       npc_load,
    output logic       mar_load,
    output logic       mdr_load,
    output logic [1:0] pc_select,
    output logic       rf_source,
    output logic       reg_write,
    output logic       mdr_source,
    output logic [1:0] alu_source,
    output logic [5:0] alu_code,
    output logic       mem_en,
    output logic       mem_rw,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,  S_F0   = 4'd1,  S_F1  = 4'd2,  S_F2  = 4'd3,
        S_DEC  = 4'd4,  S_EXR  = 4'd5,  S_EXI = 4'd6,  S_MADR = 4'd7,
        S_MRD  = 4'd8,  S_MWR  = 4'd9,  S_WBR = 4'd10, S_WBI = 4'd11,
        S_WBM  = 4'd12, S_BR   = 4'd13, S_JMP = 4'd14, S_ERR = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;

    state_t          state_r;
    state_t          state_next_s;
    logic [TW-1:0]   wait_cnt_r;
    logic            mem_wait_s;
    logic            timeout_s;
    logic            taken_s;

    assign mem_wait_s = (state_r == S_F1) || (state_r == S_MRD) || (state_r == S_MWR);
    // moc arriving in the final watchdog cycle still wins, so timeout requires moc low
    assign timeout_s  = mem_wait_s && !moc && (wait_cnt_r == TW'(MOC_TIMEOUT - 1));
    assign taken_s    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
    assign state      = state_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Watchdog counter: cleared on every state change, counts moc-low cycles in wait states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (mem_wait_s && !moc) begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_RST:  state_next_s = S_F0;
            S_F0:   state_next_s = S_F1;
            S_F1: begin
                if (moc) begin
                    state_next_s = S_F2;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_F1;
                end
            end
            S_F2:   state_next_s = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_RTYPE:                          state_next_s = S_EXR;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: state_next_s = S_EXI;
                    OP_LW, OP_SW:                      state_next_s = S_MADR;
                    OP_BEQ, OP_BNE:                    state_next_s = S_BR;
                    OP_J:                              state_next_s = S_JMP;
                    default:                           state_next_s = S_ERR;
                endcase
            end
            S_EXR:  state_next_s = S_WBR;
            S_EXI:  state_next_s = S_WBI;
            S_MADR: begin
                case (opcode)
                    OP_LW:   state_next_s = S_MRD;
                    OP_SW:   state_next_s = S_MWR;
                    default: state_next_s = S_ERR;
                endcase
            end
            S_MRD: begin
                if (moc) begin
                    state_next_s = S_WBM;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_MRD;
                end
            end
            S_MWR: begin
                if (moc) begin
                    state_next_s = S_F0;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_MWR;
                end
            end
            S_WBR, S_WBI, S_WBM, S_BR, S_JMP: state_next_s = S_F0;
            S_ERR:  state_next_s = S_ERR;
            default: state_next_s = S_ERR;
        endcase
    end

    // Output decode; mdr_load alone follows moc so the read data is captured on the completing cycle
    always_comb begin
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        npc_load   = 1'b0;
        mar_load   = 1'b0;
        mdr_load   = 1'b0;
        pc_select  = 2'b00;
        rf_source  = 1'b0;
        reg_write  = 1'b0;
        mdr_source = 1'b0;
        alu_source = 2'b00;
        alu_code   = 6'b000000;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        error      = 1'b0;
        case (state_r)
            S_F0: begin
                mar_load = 1'b1;
                npc_load = 1'b1;
            end
            S_F1, S_MRD: begin
                mem_en   = 1'b1;
                mem_rw   = 1'b1;
                mdr_load = moc;
            end
            S_F2: begin
                ir_load   = 1'b1;
                pc_load   = 1'b1;
                pc_select = 2'b00;
            end
            S_EXR: begin
                alu_source = 2'b00;
                alu_code   = funct;
            end
            S_EXI: begin
                alu_source = 2'b01;
                case (opcode)
                    OP_ANDI: alu_code = ALU_AND;
                    OP_ORI:  alu_code = ALU_OR;
                    default: alu_code = ALU_ADD;
                endcase
            end
            S_MADR: begin
                alu_source = 2'b01;
                alu_code   = ALU_ADD;
                mar_load   = 1'b1;
            end
            S_MWR: begin
                mem_en = 1'b1;
                mem_rw = 1'b0;
            end
            S_WBR: begin
                rf_source  = 1'b1;
                mdr_source = 1'b1;
                reg_write  = 1'b1;
            end
            S_WBI: begin
                rf_source  = 1'b0;
                mdr_source = 1'b1;
                reg_write  = 1'b1;
            end
            S_WBM: begin
                rf_source  = 1'b0;
                mdr_source = 1'b0;
                reg_write  = 1'b1;
            end
            S_BR: begin
                alu_source = 2'b00;
                alu_code   = ALU_SUB;
                if (taken_s) begin
                    pc_load   = 1'b1;
                    pc_select = 2'b01;
                end else begin
                    pc_load   = 1'b0;
                    pc_select = 2'b00;
                end
            end
            S_JMP: begin
                pc_load   = 1'b1;
                pc_select = 2'b10;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                error = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm: every expected value below is hand-derived
// from the state table; outputs are sampled 1 ns after the rising edge.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       moc;
    logic       ir_load, pc_load, npc_load, mar_load, mdr_load;
    logic [1:0] pc_select;
    logic       rf_source, reg_write, mdr_source;
    logic [1:0] alu_source;
    logic [5:0] alu_code;
    logic       mem_en, mem_rw, error;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MOC_TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .moc(moc),
        .ir_load(ir_load), .pc_load(pc_load), .npc_load(npc_load), .mar_load(mar_load),
        .mdr_load(mdr_load), .pc_select(pc_select), .rf_source(rf_source),
        .reg_write(reg_write), .mdr_source(mdr_source), .alu_source(alu_source),
        .alu_code(alu_code), .mem_en(mem_en), .mem_rw(mem_rw), .error(error), .state(state)
    );

    wire [24:0] all_outs = {ir_load, pc_load, npc_load, mar_load, mdr_load, pc_select,
                            rf_source, reg_write, mdr_source, alu_source, alu_code,
                            mem_en, mem_rw, error, state};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse, then leaves the DUT sampled in F0
    task automatic restart();
        reset = 1'b1;
        moc   = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // From F0: one moc-low wait cycle in F1, moc on the second, ends sampled in F2
    task automatic fetch();
        tick();
        n_cmp++;
        if (state !== 4'd2 || mem_en !== 1'b1 || mem_rw !== 1'b1 || mdr_load !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_f1: state=%0d mem_en=%b mem_rw=%b mdr_load=%b want 2 1 1 0",
                     state, mem_en, mem_rw, mdr_load);
        end
        tick();
        moc = 1'b1;
        #1;
        n_cmp++;
        if (mdr_load !== 1'b1 || state !== 4'd2) begin
            n_bad++;
            $display("FAIL fetch_mdr_load: mdr_load=%b state=%0d want 1 2", mdr_load, state);
        end
        tick();
        moc = 1'b0;
        n_cmp++;
        if (state !== 4'd3 || ir_load !== 1'b1 || pc_load !== 1'b1 || pc_select !== 2'b00 ||
            mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_f2: state=%0d ir=%b pc=%b sel=%b mem_en=%b want 3 1 1 00 0",
                     state, ir_load, pc_load, pc_select, mem_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 6'd0; funct = 6'd0; zero = 1'b0; moc = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (all_outs !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'd1 || mar_load !== 1'b1 || npc_load !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_f0: state=%0d mar=%b npc=%b want 1 1 1", state, mar_load, npc_load);
        end
    endtask

    task automatic test_add();
        int cyc;
        restart();
        opcode = 6'b000000; funct = 6'b100000;
        cyc = 1;
        fetch();
        cyc += 3;
        tick(); cyc++;
        n_cmp++;
        if (state !== 4'd4 || pc_load !== 1'b0 || reg_write !== 1'b0 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL add_dec: state=%0d pc=%b rw=%b mem_en=%b want 4 0 0 0",
                     state, pc_load, reg_write, mem_en);
        end
        tick(); cyc++;
        n_cmp++;
        if (state !== 4'd5 || alu_source !== 2'b00 || alu_code !== 6'b100000) begin
            n_bad++;
            $display("FAIL add_exr: state=%0d src=%b code=%b want 5 00 100000", state, alu_source, alu_code);
        end
        tick(); cyc++;
        n_cmp++;
        if (state !== 4'd10 || rf_source !== 1'b1 || reg_write !== 1'b1 || mdr_source !== 1'b1 ||
            pc_load !== 1'b0) begin
            n_bad++;
            $display("FAIL add_wbr: state=%0d rf=%b rw=%b mdr_src=%b pc=%b want 10 1 1 1 0",
                     state, rf_source, reg_write, mdr_source, pc_load);
        end
        tick();
        n_cmp++;
        if (state !== 4'd1 || cyc !== 7) begin
            n_bad++;
            $display("FAIL add_latency: state=%0d cycles=%0d want 1 7", state, cyc);
        end
    endtask

    task automatic test_ori();
        restart();
        opcode = 6'b001101; funct = 6'b000000;
        fetch();
        tick();
        tick();
        n_cmp++;
        if (state !== 4'd6 || alu_source !== 2'b01 || alu_code !== 6'b100101) begin
            n_bad++;
            $display("FAIL ori_exi: state=%0d src=%b code=%b want 6 01 100101", state, alu_source, alu_code);
        end
        tick();
        n_cmp++;
        if (state !== 4'd11 || rf_source !== 1'b0 || reg_write !== 1'b1 || mdr_source !== 1'b1) begin
            n_bad++;
            $display("FAIL ori_wbi: state=%0d rf=%b rw=%b mdr_src=%b want 11 0 1 1",
                     state, rf_source, reg_write, mdr_source);
        end
    endtask

    task automatic test_lw();
        restart();
        opcode = 6'b100011;
        fetch();
        tick();
        tick();
        n_cmp++;
        if (state !== 4'd7 || mar_load !== 1'b1 || alu_source !== 2'b01 || alu_code !== 6'b100000) begin
            n_bad++;
            $display("FAIL lw_madr: state=%0d mar=%b src=%b code=%b want 7 1 01 100000",
                     state, mar_load, alu_source, alu_code);
        end
        tick();
        n_cmp++;
        if (state !== 4'd8 || mem_en !== 1'b1 || mem_rw !== 1'b1 || mdr_load !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_mrd: state=%0d en=%b rw=%b mdr=%b want 8 1 1 0", state, mem_en, mem_rw, mdr_load);
        end
        moc = 1'b1;
        #1;
        n_cmp++;
        if (mdr_load !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_mdr_load: got %b want 1", mdr_load);
        end
        tick();
        moc = 1'b0;
        n_cmp++;
        if (state !== 4'd12 || mdr_source !== 1'b0 || rf_source !== 1'b0 || reg_write !== 1'b1 ||
            mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_wbm: state=%0d mdr_src=%b rf=%b rw=%b en=%b want 12 0 0 1 0",
                     state, mdr_source, rf_source, reg_write, mem_en);
        end
    endtask

    task automatic test_reset_mid_mrd();
        restart();
        opcode = 6'b100011;
        fetch();
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (all_outs !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_mid_mrd: got %h want 0", all_outs);
        end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'd1) begin
            n_bad++;
            $display("FAIL reset_seq_1: got %0d want 1", state);
        end
        tick();
        n_cmp++;
        if (state !== 4'd2) begin
            n_bad++;
            $display("FAIL reset_seq_2: got %0d want 2", state);
        end
        moc = 1'b1;
        tick();
        moc = 1'b0;
        n_cmp++;
        if (state !== 4'd3) begin
            n_bad++;
            $display("FAIL reset_seq_3: got %0d want 3", state);
        end
    endtask

    task automatic test_sw();
        int en_cycles;
        logic rw_seen;
        restart();
        opcode = 6'b101011;
        en_cycles = 0;
        rw_seen = 1'b0;
        fetch();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            rw_seen |= reg_write;
            if (mem_en === 1'b1 && mem_rw === 1'b0 && state === 4'd9) en_cycles++;
        end
        n_cmp++;
        if (en_cycles !== 3) begin
            n_bad++;
            $display("FAIL sw_hold: write-request cycles=%0d want 3", en_cycles);
        end
        moc = 1'b1;
        tick();
        moc = 1'b0;
        rw_seen |= reg_write;
        n_cmp++;
        if (state !== 4'd1 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_done: state=%0d mem_en=%b want 1 0", state, mem_en);
        end
        n_cmp++;
        if (rw_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_reg_write: got %b want 0", rw_seen);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       zs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       take [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            restart();
            opcode = ops[i];
            zero   = zs[i];
            fetch();
            tick();
            tick();
            n_cmp++;
            if (state !== 4'd13 || pc_load !== take[i] || pc_select !== (take[i] ? 2'b01 : 2'b00) ||
                alu_code !== 6'b100010) begin
                n_bad++;
                $display("FAIL branch_%0d: state=%0d pc=%b sel=%b code=%b want 13 %b %b 100010",
                         i, state, pc_load, pc_select, alu_code, take[i], take[i] ? 2'b01 : 2'b00);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        restart();
        opcode = 6'b000010;
        fetch();
        tick();
        tick();
        n_cmp++;
        if (state !== 4'd14 || pc_load !== 1'b1 || pc_select !== 2'b10) begin
            n_bad++;
            $display("FAIL jump: state=%0d pc=%b sel=%b want 14 1 10", state, pc_load, pc_select);
        end
        tick();
        n_cmp++;
        if (state !== 4'd1) begin
            n_bad++;
            $display("FAIL jump_ret: got %0d want 1", state);
        end
    endtask

    task automatic test_timeout();
        restart();
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (state !== 4'd2 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pre: state=%0d error=%b want 2 0", state, error);
        end
        tick();
        n_cmp++;
        if (state !== 4'd15 || error !== 1'b1 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: state=%0d error=%b en=%b want 15 1 0", state, error, mem_en);
        end
        moc = 1'b1;
        tick();
        tick();
        moc = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'd15 || error !== 1'b1 || pc_load !== 1'b0 || reg_write !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_hold: state=%0d error=%b pc=%b rw=%b want 15 1 0 0",
                     state, error, pc_load, reg_write);
        end
    endtask

    task automatic test_timeout_boundary();
        restart();
        tick();
        for (int i = 0; i < 15; i++) tick();
        moc = 1'b1;
        tick();
        moc = 1'b0;
        n_cmp++;
        if (state !== 4'd3 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_boundary: state=%0d error=%b want 3 0", state, error);
        end
    endtask

    task automatic test_bad_opcode();
        restart();
        opcode = 6'b111111;
        fetch();
        tick();
        tick();
        n_cmp++;
        if (state !== 4'd15 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_opcode: state=%0d error=%b want 15 1", state, error);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ori();
        test_lw();
        test_reset_mid_mrd();
        test_sw();
        test_branch();
        test_jump();
        test_timeout();
        test_timeout_boundary();
        test_bad_opcode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
